// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM state encoding,
// architectural widths and the prefetch FIFO entry layout.
package imem_fetch_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fifo_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; flush wins over push/pop.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module imem_fetch_ctrl_fetch_fifo
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fifo_entry_t wdata,
    output fifo_entry_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the ROM address, buffers returned words
// in a prefetch FIFO. Optional FETCH_MISALIGN_CHECK_EN enables the FAULT state.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  state_dbg
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_tgt;
    logic            redirect_bad;
    logic            push;
    logic            pop;
    logic            flush;
    logic            fifo_full;
    logic            fifo_empty;
    fifo_entry_t     wr_entry;
    fifo_entry_t     head;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_tgt = redirect_pc;
    assign redirect_bad = |redirect_pc[1:0];
`else
    assign redirect_tgt = redirect_pc & ~32'h3;
    assign redirect_bad = 1'b0;
`endif

    // Decode handshake: the head transfers on a cycle where inst_valid and
    // inst_ready are both high; the head stays stable while valid && !ready.
    assign pop   = inst_valid && inst_ready;
    assign flush = redirect || stop;
    assign push  = (state == ST_FETCH) && !flush && (!fifo_full || pop);

    assign wr_entry   = '{pc: pc, instr: rom_data};
    assign rom_addr   = pc;
    assign inst_valid = !fifo_empty;
    assign inst_data  = head.instr;
    assign inst_pc    = head.pc;
    assign state_dbg  = state;

    // Priority is redirect, then stop, then start; busy/fault track state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else if (redirect) begin
            pc <= redirect_tgt;
            if (redirect_bad) begin
                state <= ST_FAULT;
                busy  <= 1'b0;
                fault <= 1'b1;
            end
        end else if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else if (start && ((state == ST_IDLE) ||
                               (state == ST_FAULT && pc[1:0] == 2'b00))) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
            fault <= 1'b0;
        end else if (push) begin
            pc <= pc + XLEN'(INSTR_BYTES);
        end
    end

    imem_fetch_ctrl_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl (DEPTH = 2, RESET_PC = 0) with a small
// combinational ROM image; covers both FETCH_MISALIGN_CHECK_EN builds.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        busy;
    logic        fault;
    logic [1:0]  state_dbg;

    int vectors;
    int miscompares;

    imem_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .busy        (busy),
        .fault       (fault),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h0045_0693;
            32'h0000_0004: rom_word = 32'h0010_0713;
            32'h0000_0008: rom_word = 32'h00b7_6463;
            32'h0000_0040: rom_word = 32'h0000_8067;
            32'h0000_0044: rom_word = 32'hfc1f_f06f;
            default:       rom_word = {a[23:0], 8'h13};
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
        check({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, ".pc"},    inst_pc,   pc);
        check({tag, ".data"},  inst_data, data);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;

        // Reset values
        #3;
        check("rst.valid", {31'd0, inst_valid}, 32'd0);
        check("rst.data",  inst_data, 32'h0);
        check("rst.pc",    inst_pc,   32'h0);
        check("rst.addr",  rom_addr,  32'h0);
        check("rst.busy",  {31'd0, busy},  32'd0);
        check("rst.fault", {31'd0, fault}, 32'd0);
        check("rst.state", {30'd0, state_dbg}, 32'd0);
        tick();
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        tick();

        // Start and stream three words at one per cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start.busy",  {31'd0, busy}, 32'd1);
        check("start.addr",  rom_addr, 32'h0);
        check("start.valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_head("str0", 32'h0, 32'h0045_0693);
        check("str0.addr", rom_addr, 32'h4);
        tick();
        check_head("str1", 32'h4, 32'h0010_0713);
        tick();
        check_head("str2", 32'h8, 32'h00b7_6463);
        check("str2.addr", rom_addr, 32'hC);

        // Stop in FETCH, then resume from the held address
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop.valid", {31'd0, inst_valid}, 32'd0);
        check("stop.busy",  {31'd0, busy}, 32'd0);
        check("stop.addr",  rom_addr, 32'hC);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("resume.addr", rom_addr, 32'hC);
        tick();
        check_head("resume0", 32'hC, 32'h0000_0C13);
        tick();
        check_head("resume1", 32'h10, 32'h0000_1013);

        // Redirect with a same-cycle pop of the 0x10 head
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("redir.valid", {31'd0, inst_valid}, 32'd0);
        check("redir.addr",  rom_addr, 32'h40);
        check("redir.busy",  {31'd0, busy}, 32'd1);
        tick();
        check_head("redir0", 32'h40, 32'h0000_8067);
        tick();
        check_head("redir1", 32'h44, 32'hfc1f_f06f);

        // Back-pressure: idle, reload pc 0 in IDLE, start with ready low
        stop = 1'b1;
        tick();
        stop        = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        check("idle_redir.busy", {31'd0, busy}, 32'd0);
        check("idle_redir.addr", rom_addr, 32'h0);
        inst_ready = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("bp.s1.valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_head("bp.s2", 32'h0, 32'h0045_0693);
        check("bp.s2.addr", rom_addr, 32'h4);
        tick();
        check_head("bp.s3", 32'h0, 32'h0045_0693);
        check("bp.s3.addr", rom_addr, 32'h8);
        tick();
        tick();
        check_head("bp.s5", 32'h0, 32'h0045_0693);
        check("bp.s5.addr", rom_addr, 32'h8);
        inst_ready = 1'b1;
        tick();
        check_head("bp.s6", 32'h4, 32'h0010_0713);
        check("bp.s6.addr", rom_addr, 32'hC);
        tick();
        check_head("bp.s7", 32'h8, 32'h00b7_6463);
        tick();
        check_head("bp.s8", 32'hC, 32'h0000_0C13);
        inst_ready = 1'b0;
        tick();
        check_head("bp.s9", 32'hC, 32'h0000_0C13);
        check("bp.s9.addr", rom_addr, 32'h14);

        // Asynchronous reset with the FIFO full
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", {31'd0, inst_valid}, 32'd0);
        check("arst.addr",  rom_addr, 32'h0);
        check("arst.busy",  {31'd0, busy}, 32'd0);
        check("arst.state", {30'd0, state_dbg}, 32'd0);
        check("arst.data",  inst_data, 32'h0);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        tick();
        check("arst.post.valid", {31'd0, inst_valid}, 32'd0);

        // Misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis.fault", {31'd0, fault}, 32'd1);
        check("mis.busy",  {31'd0, busy},  32'd0);
        check("mis.addr",  rom_addr, 32'h42);
        check("mis.state", {30'd0, state_dbg}, 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mis.start.fault", {31'd0, fault}, 32'd1);
        check("mis.start.busy",  {31'd0, busy},  32'd0);
        tick();
        check("mis.nopush", {31'd0, inst_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h44;
        tick();
        redirect = 1'b0;
        check("mis.realign.addr", rom_addr, 32'h44);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mis.resume.busy",  {31'd0, busy},  32'd1);
        check("mis.resume.fault", {31'd0, fault}, 32'd0);
        tick();
        check_head("mis.resume", 32'h44, 32'hfc1f_f06f);
`else
        check("mis.addr",  rom_addr, 32'h40);
        check("mis.fault", {31'd0, fault}, 32'd0);
        check("mis.busy",  {31'd0, busy},  32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mis.start.addr", rom_addr, 32'h40);
        tick();
        check_head("mis.f0", 32'h40, 32'h0000_8067);
        tick();
        check_head("mis.f1", 32'h44, 32'hfc1f_f06f);
`endif

        // PC wrap from the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap.valid", {31'd0, inst_valid}, 32'd0);
        check("wrap.addr",  rom_addr, 32'hFFFF_FFFC);
        tick();
        check_head("wrap0", 32'hFFFF_FFFC, 32'hFFFF_FC13);
        check("wrap0.addr", rom_addr, 32'h0);
        tick();
        check_head("wrap1", 32'h0, 32'h0045_0693);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
